// File: rtl/top2_pkg.sv
// Shared types and helpers for the frame scheduler: FSM state encoding and
// the round-robin requester pick.
package top2_pkg;

  localparam int unsigned MAX_REQ = 16;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    RESULT
  } state_e;

  typedef struct packed {
    logic       found;
    logic [3:0] idx;
  } pick_t;

  // First set request bit at or above ptr, wrapping at n requesters.
  function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] req,
                                    input logic [3:0]         ptr,
                                    input int unsigned        n);
    pick_t       r;
    int unsigned j;
    r = '0;
    for (int unsigned i = 0; i < MAX_REQ; i++) begin
      j = 32'(ptr) + i;
      if (j >= n) j = j - n;
      if (!r.found && (i < n) && req[j[3:0]]) begin
        r.found = 1'b1;
        r.idx   = j[3:0];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/top2_tracker.sv
// Largest / second-largest distinct value tracker for one frame.
// Outputs show the tracker state including the beat presented this cycle,
// so the scheduler can capture a complete result on the in_last beat.
module top2_tracker #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_W      = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  beat,
  input  logic [DATA_WIDTH-1:0] data,
  output logic [DATA_WIDTH-1:0] max1,
  output logic [DATA_WIDTH-1:0] max2,
  output logic                  max2_ok,
  output logic [CNT_W-1:0]      count
);

  logic [DATA_WIDTH-1:0] max1_q, max1_d;
  logic [DATA_WIDTH-1:0] max2_q, max2_d;
  logic                  max2_ok_q, max2_ok_d;
  logic                  seen_q, seen_d;
  logic [CNT_W-1:0]      count_q, count_d;

  // Next tracker state: clear, or fold in one accepted beat.
  always_comb begin
    max1_d    = max1_q;
    max2_d    = max2_q;
    max2_ok_d = max2_ok_q;
    seen_d    = seen_q;
    count_d   = count_q;
    if (clr) begin
      max1_d    = '0;
      max2_d    = '0;
      max2_ok_d = 1'b0;
      seen_d    = 1'b0;
      count_d   = '0;
    end else if (beat) begin
      if (count_q != '1) count_d = count_q + 1'b1;
      if (!seen_q) begin
        max1_d = data;
        seen_d = 1'b1;
      end else if (data > max1_q) begin
        max2_d    = max1_q;
        max2_ok_d = 1'b1;
        max1_d    = data;
      end else if ((data < max1_q) && (!max2_ok_q || (data > max2_q))) begin
        max2_d    = data;
        max2_ok_d = 1'b1;
      end
    end
  end

  // Tracker registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      max1_q    <= '0;
      max2_q    <= '0;
      max2_ok_q <= 1'b0;
      seen_q    <= 1'b0;
      count_q   <= '0;
    end else begin
      max1_q    <= max1_d;
      max2_q    <= max2_d;
      max2_ok_q <= max2_ok_d;
      seen_q    <= seen_d;
      count_q   <= count_d;
    end
  end

  assign max1    = max1_d;
  assign max2    = max2_d;
  assign max2_ok = max2_ok_d;
  assign count   = count_d;

endmodule

// File: rtl/top2_frame_sched.sv
// Round-robin frame scheduler: grants one requester at a time the shared
// sample bus, tracks the frame's top two distinct values, and holds the
// result until the consumer accepts it.
module top2_frame_sched
  import top2_pkg::*;
#(
  parameter  int DATA_WIDTH = 8,
  parameter  int NUM_REQ    = 4,
  parameter  int CNT_W      = 8,
  localparam int ID_W       = $clog2(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req,
  output logic [NUM_REQ-1:0]    gnt,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_last,
  output logic                  in_ready,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [DATA_WIDTH-1:0] res_max1,
  output logic [DATA_WIDTH-1:0] res_max2,
  output logic                  res_max2_ok,
  output logic [CNT_W-1:0]      res_count,
  output logic [ID_W-1:0]       res_id
);

  state_e                state_q, state_d;
  logic [NUM_REQ-1:0]    gnt_q, gnt_d;
  logic [ID_W-1:0]       ptr_q, ptr_d;
  logic [ID_W-1:0]       cur_q, cur_d;
  logic                  res_valid_q, res_valid_d;
  logic [DATA_WIDTH-1:0] res_max1_q, res_max1_d;
  logic [DATA_WIDTH-1:0] res_max2_q, res_max2_d;
  logic                  res_max2_ok_q, res_max2_ok_d;
  logic [CNT_W-1:0]      res_count_q, res_count_d;
  logic [ID_W-1:0]       res_id_q, res_id_d;

  logic                  trk_clr, trk_beat;
  logic [DATA_WIDTH-1:0] trk_max1, trk_max2;
  logic                  trk_max2_ok;
  logic [CNT_W-1:0]      trk_count;
  pick_t                 pick;

  assign pick     = rr_pick(MAX_REQ'(req), 4'(ptr_q), NUM_REQ);
  assign trk_beat = (state_q == STREAM) && in_valid;

  top2_tracker #(
    .DATA_WIDTH (DATA_WIDTH),
    .CNT_W      (CNT_W)
  ) u_tracker (
    .clk     (clk),
    .rst     (rst),
    .clr     (trk_clr),
    .beat    (trk_beat),
    .data    (in_data),
    .max1    (trk_max1),
    .max2    (trk_max2),
    .max2_ok (trk_max2_ok),
    .count   (trk_count)
  );

  // Next state: arbitrate in IDLE, close the frame on in_last, wait for handshake.
  always_comb begin
    state_d       = state_q;
    gnt_d         = gnt_q;
    ptr_d         = ptr_q;
    cur_d         = cur_q;
    res_valid_d   = res_valid_q;
    res_max1_d    = res_max1_q;
    res_max2_d    = res_max2_q;
    res_max2_ok_d = res_max2_ok_q;
    res_count_d   = res_count_q;
    res_id_d      = res_id_q;
    trk_clr       = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick.found) begin
          state_d                  = STREAM;
          gnt_d                    = '0;
          gnt_d[ID_W'(pick.idx)]   = 1'b1;
          cur_d                    = ID_W'(pick.idx);
          trk_clr                  = 1'b1;
        end
      end
      STREAM: begin
        if (in_valid && in_last) begin
          state_d       = RESULT;
          gnt_d         = '0;
          res_valid_d   = 1'b1;
          res_max1_d    = trk_max1;
          res_max2_d    = trk_max2;
          res_max2_ok_d = trk_max2_ok;
          res_count_d   = trk_count;
          res_id_d      = cur_q;
          ptr_d         = (cur_q == ID_W'(NUM_REQ - 1)) ? '0 : cur_q + 1'b1;
        end
      end
      RESULT: begin
        if (res_ready) begin
          state_d     = IDLE;
          res_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Scheduler and result registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      gnt_q         <= '0;
      ptr_q         <= '0;
      cur_q         <= '0;
      res_valid_q   <= 1'b0;
      res_max1_q    <= '0;
      res_max2_q    <= '0;
      res_max2_ok_q <= 1'b0;
      res_count_q   <= '0;
      res_id_q      <= '0;
    end else begin
      state_q       <= state_d;
      gnt_q         <= gnt_d;
      ptr_q         <= ptr_d;
      cur_q         <= cur_d;
      res_valid_q   <= res_valid_d;
      res_max1_q    <= res_max1_d;
      res_max2_q    <= res_max2_d;
      res_max2_ok_q <= res_max2_ok_d;
      res_count_q   <= res_count_d;
      res_id_q      <= res_id_d;
    end
  end

  assign gnt         = gnt_q;
  assign in_ready    = (state_q == STREAM);
  assign res_valid   = res_valid_q;
  assign res_max1    = res_max1_q;
  assign res_max2    = res_max2_q;
  assign res_max2_ok = res_max2_ok_q;
  assign res_count   = res_count_q;
  assign res_id      = res_id_q;

endmodule

// File: doc/top2_frame_sched.md
# top2_frame_sched

Round-robin scheduler that shares one largest/second-largest tracker between NUM_REQ requesters, one frame at a time. A requester raises req, receives a grant, streams a frame over the shared valid/ready bus, and gets back the frame's largest value, second-largest distinct value, beat count and its own ID. The block sits between the requester-side input mux and the downstream result consumer.

## Interface
- DATA_WIDTH, 8, sample width (unsigned)
- NUM_REQ, 4, number of requesters (2..16)
- CNT_W, 8, frame beat-count width; count saturates at 2^CNT_W-1
- clk  input  1  clock, all logic on rising edge
- rst  input  1  asynchronous, active-low reset
- req  input  NUM_REQ  per-requester frame request, level
- gnt  output  NUM_REQ  one-hot grant, registered; reset 0
- in_valid  input  1  sample valid from the granted requester
- in_data  input  DATA_WIDTH  sample
- in_last  input  1  final sample of frame, qualified by in_valid
- in_ready  output  1  sample accepted when in_valid && in_ready; reset 0
- res_valid  output  1  result available; reset 0
- res_ready  input  1  consumer accepts result
- res_max1  output  DATA_WIDTH  largest sample of frame; reset 0
- res_max2  output  DATA_WIDTH  largest sample strictly below res_max1; reset 0
- res_max2_ok  output  1  1 if frame held at least two distinct values; reset 0
- res_count  output  CNT_W  accepted beats in frame (saturating); reset 0
- res_id  output  $clog2(NUM_REQ)  index of the served requester; reset 0

## Operation
- States: IDLE, STREAM, RESULT. Reset state IDLE; round-robin pointer reset to 0 (requester 0 has highest priority first).
- IDLE: if any req bit set, pick first set bit searching from pointer upward with wrap; next cycle gnt = that one-hot, in_ready = 1, tracker cleared (max1=0, max2=0, seen=0, max2_ok=0, count=0), state STREAM. No req: stay.
- STREAM: each accepted beat updates tracker: first beat of frame loads max1; later beats: data > max1 → max2 <= max1, max2_ok <= 1, max1 <= data; max2 < data < max1 (or !max2_ok and data < max1) → max2 <= data, max2_ok <= 1; data == max1 → no change. count increments, saturating.
- Accepted beat with in_last: next cycle gnt = 0, in_ready = 0, res_* loaded from tracker including that final beat, res_valid = 1, state RESULT; pointer <= served index + 1 (wrap).
- req deassertion during STREAM is ignored; frame ends only on in_last. in_valid while not granted is ignored.
- RESULT: res_* held stable while res_valid && !res_ready. Handshake (res_valid && res_ready) → res_valid = 0, state IDLE next cycle; res_* retain last values.
- Single-beat frame: max1 = data, max2 = 0, max2_ok = 0, count = 1.

## Timing
- Grant latency: req seen in IDLE → gnt/in_ready high 1 cycle later.
- Result latency: in_last beat at edge N → res_valid high after edge N (visible cycle N+1).
- Minimum turnaround: result handshake cycle → IDLE → arbitration → gnt, i.e. 2 cycles between res handshake and next gnt.
- Full throughput inside a frame: one beat per cycle, in_ready constant 1 in STREAM.
- Reset asserted mid-frame or mid-result: all outputs and state return to reset values immediately; partial frame discarded; pointer back to 0.

## Structure
- Package top2_pkg: state enum (IDLE, STREAM, RESULT), round-robin pick function (req, pointer → index, found).
- Sub-module top2_tracker: clear, beat valid, data in; max1, max2, max2_ok, count out. Scheduler owns FSM, arbitration, gnt, result registers.

## Test plan
- Single requester 2, frame 3,7,5,7(last) → gnt=0100 one cycle after req; result max1=7, max2=5, max2_ok=1, count=4, id=2.
- All four req held high, one-beat frames → grants in order 0,1,2,3,0 (round-robin wrap).
- Frame 9,9,9(last) → max1=9, max2=0, max2_ok=0, count=3; frame 0,4(last) → max1=4, max2=0, max2_ok=1.
- res_ready held low 5 cycles after result → res_* stable, gnt stays 0, no new grant until handshake; then new gnt 2 cycles after handshake.
- in_valid gaps and req dropped mid-frame 1,2,(gap),3(last) → frame continues, max1=3, max2=2, count=3.
- rst pulsed low during STREAM after 2 beats → gnt, in_ready, res_valid 0 immediately; next frame from requester 0 reports only its own beats.
